// File: rtl/twowire_io_regs_pkg.sv
// Shared types and limits for the Two-Wire Debug pad IO register bank.
// Provides the per-pin output FSM state encoding, counter widths and the
// parameter legality helper used by the top level.
package twowire_io_regs_pkg;

   // Output FSM state encodings (fixed so pad-side debug views stay stable)
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_PARK  = 2'd2
   } io_state_e;

   localparam int unsigned PARK_CNT_W = 3;   // holds PARK_CYCLES up to 7
   localparam int unsigned MAX_PINS   = 8;
   localparam int unsigned MAX_SYNC   = 4;
   localparam int unsigned MAX_FILTER = 15;
   localparam int unsigned MAX_PARK   = 7;

   // Inclusive range check used for parameter legality
   function automatic bit param_in_range(input int unsigned v,
                                         input int unsigned lo,
                                         input int unsigned hi);
      return (v >= lo) && (v <= hi);
   endfunction

endpackage

// File: rtl/twowire_io_regs_pin.sv
// One Two-Wire Debug pad channel.
// Ports:
//   dck, drst        clock, synchronous active-high reset
//   dout, doe        core output data / output enable
//   di               raw asynchronous pad input
//   dout_q, doe_q    registered pad output data / enable (with park on release)
//   di_q             synchronised, deglitched input
//   di_rise/di_fall  single-cycle pulses coincident with di_q edges
//   park_busy        high while the channel holds the line high after release
`ifndef TWOWIRE_REG_KEEP_ATTR
`define TWOWIRE_REG_KEEP_ATTR (* keep = "true" *)
`endif

module twowire_io_regs_pin
   import twowire_io_regs_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FILTER_LEN  = 1,
   parameter int unsigned PARK_CYCLES = 1
) (
   input  logic dck,
   input  logic drst,
   input  logic dout,
   input  logic doe,
   input  logic di,
   `TWOWIRE_REG_KEEP_ATTR output logic dout_q,
   `TWOWIRE_REG_KEEP_ATTR output logic doe_q,
   `TWOWIRE_REG_KEEP_ATTR output logic di_q,
   `TWOWIRE_REG_KEEP_ATTR output logic di_rise,
   `TWOWIRE_REG_KEEP_ATTR output logic di_fall,
   `TWOWIRE_REG_KEEP_ATTR output logic park_busy
);

   localparam int unsigned FCW = $clog2(FILTER_LEN + 1);
   localparam logic [FCW-1:0]        FILT_LAST = FCW'(FILTER_LEN - 1);
   localparam logic [PARK_CNT_W-1:0] PARK_LAST = PARK_CNT_W'(PARK_CYCLES);

   `TWOWIRE_REG_KEEP_ATTR io_state_e              st_q;
   `TWOWIRE_REG_KEEP_ATTR logic [PARK_CNT_W-1:0]  park_cnt_q;
   `TWOWIRE_REG_KEEP_ATTR logic [SYNC_STAGES-1:0] sync_q;
   `TWOWIRE_REG_KEEP_ATTR logic [FCW-1:0]         filt_cnt_q;

   logic [SYNC_STAGES-1:0] sync_d;
   logic [FCW-1:0]         filt_cnt_d;
   logic                   di_s;
   logic                   di_q_d;
   logic                   di_rise_d;
   logic                   di_fall_d;

   // Output FSM: park drives the line high with enable held so it never floats low
   always_ff @(posedge dck) begin
      if (drst) begin
         st_q       <= ST_IDLE;
         park_cnt_q <= '0;
         dout_q     <= 1'b0;
         doe_q      <= 1'b0;
         park_busy  <= 1'b0;
      end else begin
         case (st_q)
            ST_IDLE: begin
               dout_q    <= dout;
               doe_q     <= doe;
               park_busy <= 1'b0;
               if (doe) st_q <= ST_DRIVE;
            end
            ST_DRIVE: begin
               if (doe) begin
                  dout_q <= dout;
                  doe_q  <= 1'b1;
               end else if (PARK_CYCLES > 0) begin
                  // park cycle 1 starts now; counter tracks completed park cycles
                  st_q       <= ST_PARK;
                  park_cnt_q <= PARK_CNT_W'(1);
                  dout_q     <= 1'b1;
                  doe_q      <= 1'b1;
                  park_busy  <= 1'b1;
               end else begin
                  st_q   <= ST_IDLE;
                  dout_q <= dout;
                  doe_q  <= 1'b0;
               end
            end
            ST_PARK: begin
               if (doe) begin
                  // core reclaims the line: abort park
                  st_q       <= ST_DRIVE;
                  park_cnt_q <= '0;
                  dout_q     <= dout;
                  doe_q      <= 1'b1;
                  park_busy  <= 1'b0;
               end else if (park_cnt_q == PARK_LAST) begin
                  st_q       <= ST_IDLE;
                  park_cnt_q <= '0;
                  dout_q     <= dout;
                  doe_q      <= 1'b0;
                  park_busy  <= 1'b0;
               end else begin
                  park_cnt_q <= park_cnt_q + PARK_CNT_W'(1);
               end
            end
            default: begin
               st_q       <= ST_IDLE;
               park_cnt_q <= '0;
               dout_q     <= 1'b0;
               doe_q      <= 1'b0;
               park_busy  <= 1'b0;
            end
         endcase
      end
   end

   // Input path next state: shift synchroniser, count stable mismatch cycles
   always_comb begin
      sync_d     = SYNC_STAGES'({sync_q, di});
      di_s       = sync_q[SYNC_STAGES-1];
      filt_cnt_d = '0;
      di_q_d     = di_q;
      di_rise_d  = 1'b0;
      di_fall_d  = 1'b0;
      if (di_s != di_q) begin
         if (filt_cnt_q == FILT_LAST) begin
            // FILTER_LEN-th consecutive differing cycle: accept the change
            di_q_d    = di_s;
            di_rise_d = di_s;
            di_fall_d = ~di_s;
         end else begin
            filt_cnt_d = filt_cnt_q + FCW'(1);
         end
      end
   end

   // Input path registers
   always_ff @(posedge dck) begin
      if (drst) begin
         sync_q     <= '0;
         filt_cnt_q <= '0;
         di_q       <= 1'b0;
         di_rise    <= 1'b0;
         di_fall    <= 1'b0;
      end else begin
         sync_q     <= sync_d;
         filt_cnt_q <= filt_cnt_d;
         di_q       <= di_q_d;
         di_rise    <= di_rise_d;
         di_fall    <= di_fall_d;
      end
   end

endmodule

// File: rtl/twowire_io_regs.sv
// Two-Wire Debug pad IO register bank: N_PINS independent channels between
// the DTM core and the pad cells.
// Ports:
//   dck, drst        clock, synchronous active-high reset
//   dout, doe, di    per-pin core data / enable and raw pad input
//   dout_q, doe_q    registered pad output data / enable
//   di_q             synchronised, filtered pad input
//   di_rise/di_fall  edge pulses on di_q
//   park_busy        per-pin park indicator
module twowire_io_regs
   import twowire_io_regs_pkg::*;
#(
   parameter int unsigned N_PINS      = 1,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FILTER_LEN  = 1,
   parameter int unsigned PARK_CYCLES = 1
) (
   input  logic              dck,
   input  logic              drst,
   input  logic [N_PINS-1:0] dout,
   input  logic [N_PINS-1:0] doe,
   input  logic [N_PINS-1:0] di,
   output logic [N_PINS-1:0] dout_q,
   output logic [N_PINS-1:0] doe_q,
   output logic [N_PINS-1:0] di_q,
   output logic [N_PINS-1:0] di_rise,
   output logic [N_PINS-1:0] di_fall,
   output logic [N_PINS-1:0] park_busy
);

   // Parameter legality
   if (!param_in_range(N_PINS, 1, MAX_PINS)) begin : g_bad_n_pins
      $error("twowire_io_regs: N_PINS out of range 1..8");
   end
   if (!param_in_range(SYNC_STAGES, 1, MAX_SYNC)) begin : g_bad_sync
      $error("twowire_io_regs: SYNC_STAGES out of range 1..4");
   end
   if (!param_in_range(FILTER_LEN, 1, MAX_FILTER)) begin : g_bad_filter
      $error("twowire_io_regs: FILTER_LEN out of range 1..15");
   end
   if (!param_in_range(PARK_CYCLES, 0, MAX_PARK)) begin : g_bad_park
      $error("twowire_io_regs: PARK_CYCLES out of range 0..7");
   end

   // One fully independent channel per pin
   for (genvar p = 0; p < N_PINS; p++) begin : g_pin
      twowire_io_regs_pin #(
         .SYNC_STAGES (SYNC_STAGES),
         .FILTER_LEN  (FILTER_LEN),
         .PARK_CYCLES (PARK_CYCLES)
      ) u_pin (
         .dck       (dck),
         .drst      (drst),
         .dout      (dout[p]),
         .doe       (doe[p]),
         .di        (di[p]),
         .dout_q    (dout_q[p]),
         .doe_q     (doe_q[p]),
         .di_q      (di_q[p]),
         .di_rise   (di_rise[p]),
         .di_fall   (di_fall[p]),
         .park_busy (park_busy[p])
      );
   end

endmodule
